// File: rtl/ps2_mouse_pkg.sv
// Shared definitions for the PS/2 mouse tracker: packet FSM states and byte0 bit positions.
package ps2_mouse_pkg;

   typedef enum logic [2:0] {
      S_B0  = 3'd0,
      S_B1  = 3'd1,
      S_B2  = 3'd2,
      S_B3  = 3'd3,
      S_UPD = 3'd4
   } ps2State_e;

   localparam int unsigned SYNC = 3;
   localparam int unsigned XS   = 4;
   localparam int unsigned YS   = 5;
   localparam int unsigned XO   = 6;
   localparam int unsigned YO   = 7;

   // PS/2 motion is a 9-bit two's complement value split between byte0 (sign) and a data byte.
   function automatic logic signed [8:0] packDelta(input logic sign, input logic [7:0] mag);
      return $signed({sign, mag});
   endfunction

endpackage

// File: rtl/ps2_packet_assembler.sv
// Collects PS/2 mouse bytes into a packet with sync-bit alignment and an inter-byte timeout.
// With MOUSE_WHEEL_EN defined, packets carry a fourth (wheel) byte.
module ps2_packet_assembler
   import ps2_mouse_pkg::*;
#(
   parameter int TIMEOUT = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       pkt_valid,
   output logic [7:0] byte0,
   output logic [7:0] byte1,
   output logic [7:0] byte2
`ifdef MOUSE_WHEEL_EN
   ,
   output logic [7:0] byte3
`endif
);

   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   ps2State_e     state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [7:0]    b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
   logic          inPacket;
`ifdef MOUSE_WHEEL_EN
   logic [7:0]    b3_q, b3_d;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_B0;
         timer_q <= '0;
         b0_q    <= '0;
         b1_q    <= '0;
         b2_q    <= '0;
`ifdef MOUSE_WHEEL_EN
         b3_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         b0_q    <= b0_d;
         b1_q    <= b1_d;
         b2_q    <= b2_d;
`ifdef MOUSE_WHEEL_EN
         b3_q    <= b3_d;
`endif
      end
   end

   // A byte arriving on the very cycle the timer expires still counts; otherwise an
   // expired timer abandons the partial packet without touching any output.
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      b0_d     = b0_q;
      b1_d     = b1_q;
      b2_d     = b2_q;
`ifdef MOUSE_WHEEL_EN
      b3_d     = b3_q;
`endif
      inPacket = (state_q == S_B1) || (state_q == S_B2) || (state_q == S_B3);

      if (inPacket) begin
         if (rx_valid) begin
            timer_d = '0;
         end else if (timer_q == TLAST) begin
            timer_d = '0;
            state_d = S_B0;
         end else begin
            timer_d = timer_q + 1'b1;
         end
      end else begin
         timer_d = '0;
      end

      case (state_q)
         S_B0: begin
            if (rx_valid && rx_data[SYNC]) begin
               b0_d    = rx_data;
               state_d = S_B1;
            end
         end
         S_B1: begin
            if (rx_valid) begin
               b1_d    = rx_data;
               state_d = S_B2;
            end
         end
         S_B2: begin
            if (rx_valid) begin
               b2_d    = rx_data;
`ifdef MOUSE_WHEEL_EN
               state_d = S_B3;
`else
               state_d = S_UPD;
`endif
            end
         end
`ifdef MOUSE_WHEEL_EN
         S_B3: begin
            if (rx_valid) begin
               b3_d    = rx_data;
               state_d = S_UPD;
            end
         end
`endif
         S_UPD: begin
            state_d = S_B0;
         end
         default: begin
            state_d = S_B0;
         end
      endcase
   end

   assign pkt_valid = (state_q == S_UPD);
   assign byte0     = b0_q;
   assign byte1     = b1_q;
   assign byte2     = b2_q;
`ifdef MOUSE_WHEEL_EN
   assign byte3     = b3_q;
`endif

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse tracker: clamped absolute cursor, buttons and warp port on top of the packet assembler.
// Optional feature macro MOUSE_WHEEL_EN adds IntelliMouse wheel accumulation and the wheel port.
module ps2_mouse_tracker
   import ps2_mouse_pkg::*;
#(
   parameter int CW        = 12,
   parameter int MAX_X     = 1023,
   parameter int MAX_Y     = 767,
   parameter int INIT_X    = 0,
   parameter int INIT_Y    = 0,
   parameter int DIV_SHIFT = 0,
   parameter int TIMEOUT   = 50000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   input  logic          load,
   input  logic [CW-1:0] load_x,
   input  logic [CW-1:0] load_y,
   output logic [CW-1:0] pos_x,
   output logic [CW-1:0] pos_y,
   output logic [2:0]    btn,
   output logic          pkt_strobe,
   output logic          ovf_err
`ifdef MOUSE_WHEEL_EN
   ,
   output logic [7:0]    wheel
`endif
);

   localparam int SW = CW + 2;

   logic          pktValid;
   logic [7:0]    byte0, byte1, byte2;
`ifdef MOUSE_WHEEL_EN
   logic [7:0]    byte3;
   logic [7:0]    wheel_q, wheel_d;
`endif

   logic [CW-1:0]        posX_q, posX_d, posY_q, posY_d;
   logic [2:0]           btn_q, btn_d;
   logic                 strobe_q, strobe_d;
   logic                 ovf_q, ovf_d;
   logic signed [8:0]    dxRaw, dyRaw, dxScaled, dyScaled;
   logic signed [SW-1:0] sumX, sumY;
   logic [CW-1:0]        loadXClamped, loadYClamped;
   logic                 unusedSync;

   ps2_packet_assembler #(
      .TIMEOUT(TIMEOUT)
   ) u_assembler (
      .clk      (clk),
      .reset    (reset),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .pkt_valid(pktValid),
      .byte0    (byte0),
      .byte1    (byte1),
      .byte2    (byte2)
`ifdef MOUSE_WHEEL_EN
      ,
      .byte3    (byte3)
`endif
   );

   assign unusedSync = byte0[SYNC];

   function automatic logic [CW-1:0] clampCoord(input logic signed [SW-1:0] v, input int maxv);
      logic signed [SW-1:0] maxS;
      maxS = SW'(maxv);
      if (v < 0) begin
         return '0;
      end else if (v > maxS) begin
         return CW'(maxv);
      end else begin
         return v[CW-1:0];
      end
   endfunction

   // Screen Y grows downward while PS/2 +dy means up, hence the subtraction for Y.
   always_comb begin
      dxRaw    = byte0[XO] ? 9'sd0 : packDelta(byte0[XS], byte1);
      dyRaw    = byte0[YO] ? 9'sd0 : packDelta(byte0[YS], byte2);
      dxScaled = dxRaw >>> DIV_SHIFT;
      dyScaled = dyRaw >>> DIV_SHIFT;
      sumX     = $signed({2'b00, posX_q}) + $signed({{(SW-9){dxScaled[8]}}, dxScaled});
      sumY     = $signed({2'b00, posY_q}) - $signed({{(SW-9){dyScaled[8]}}, dyScaled});
      loadXClamped = (load_x > CW'(MAX_X)) ? CW'(MAX_X) : load_x;
      loadYClamped = (load_y > CW'(MAX_Y)) ? CW'(MAX_Y) : load_y;
   end

   // A warp overrides the packet's motion, but buttons, wheel and strobes still follow the packet.
   always_comb begin
      posX_d   = posX_q;
      posY_d   = posY_q;
      btn_d    = btn_q;
      strobe_d = pktValid;
      ovf_d    = pktValid && (byte0[XO] || byte0[YO]);
`ifdef MOUSE_WHEEL_EN
      wheel_d  = wheel_q;
`endif
      if (pktValid) begin
         posX_d  = clampCoord(sumX, MAX_X);
         posY_d  = clampCoord(sumY, MAX_Y);
         btn_d   = byte0[2:0];
`ifdef MOUSE_WHEEL_EN
         wheel_d = wheel_q + {{4{byte3[3]}}, byte3[3:0]};
`endif
      end
      if (load) begin
         posX_d = loadXClamped;
         posY_d = loadYClamped;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         posX_q   <= CW'(INIT_X);
         posY_q   <= CW'(INIT_Y);
         btn_q    <= '0;
         strobe_q <= 1'b0;
         ovf_q    <= 1'b0;
`ifdef MOUSE_WHEEL_EN
         wheel_q  <= '0;
`endif
      end else begin
         posX_q   <= posX_d;
         posY_q   <= posY_d;
         btn_q    <= btn_d;
         strobe_q <= strobe_d;
         ovf_q    <= ovf_d;
`ifdef MOUSE_WHEEL_EN
         wheel_q  <= wheel_d;
`endif
      end
   end

   assign pos_x      = posX_q;
   assign pos_y      = posY_q;
   assign btn        = btn_q;
   assign pkt_strobe = strobe_q;
   assign ovf_err    = ovf_q;
`ifdef MOUSE_WHEEL_EN
   assign wheel      = wheel_q;
`endif

endmodule
